traffic_light_monitor: RTL and testbench

Lamp-side monitor for the 4-road intersection controller. Samples the twelve lamp outputs, decodes the active road and phase, and checks the sequence: one non-red road at a time, phases advancing 1G→1Y→2G→2Y→3G→3Y→4G→4Y→1G, and dwell limits per phase. Any violation latches a fault code for the safety/conflict-monitor path until it is explicitly cleared. Sits beside the controller, driven by the same lamp nets that feed the pad drivers.

---
 rtl/traffic_light_monitor.sv | 185 ++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Lamp-side sequence monitor for the 4-road intersection controller: registers the twelve
// lamp nets, decodes road/phase, and latches the first ordering/dwell violation until cleared.
module traffic_light_monitor #(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 1,
  parameter int ROT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red1,
  input  logic             yellow1,
  input  logic             green1,
  input  logic             red2,
  input  logic             yellow2,
  input  logic             green2,
  input  logic             red3,
  input  logic             yellow3,
  input  logic             green3,
  input  logic             red4,
  input  logic             yellow4,
  input  logic             green4,
  input  logic             fault_clear,
  output logic [2:0]       phase,
  output logic             phase_valid,
  output logic [7:0]       dwell,
  output logic [ROT_W-1:0] rotations,
  output logic             fault,
  output logic [2:0]       fault_code
);

  typedef enum logic [1:0] {SYNC = 2'd0, TRACK = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [11:0] ALL_RED    = 12'b100_100_100_100;
  localparam logic [7:0]  MIN_D      = 8'(MIN_DWELL);
  localparam logic [7:0]  MAX_D      = 8'(MAX_DWELL);
  localparam logic [2:0]  C_NONE     = 3'd0;
  localparam logic [2:0]  C_CONFLICT = 3'd1;
  localparam logic [2:0]  C_ILLEGAL  = 3'd2;
  localparam logic [2:0]  C_ALL_RED  = 3'd3;
  localparam logic [2:0]  C_SKIP     = 3'd4;
  localparam logic [2:0]  C_SHORT    = 3'd5;
  localparam logic [2:0]  C_STUCK    = 3'd6;

  state_t           state_reg, state_next;
  logic [11:0]      lamp_q;
  logic [2:0]       phase_reg, phase_next;
  logic [7:0]       dwell_reg, dwell_next;
  logic [ROT_W-1:0] rot_reg, rot_next;
  logic [2:0]       code_reg, code_next;
  logic             first_reg, first_next;

  logic [3:0] road_active, road_yellow, road_illegal;
  logic [2:0] active_cnt;
  logic [1:0] active_idx;
  logic [2:0] lamp_phase, phase_inc, viol_code;
  logic       is_conflict, is_illegal, is_all_red;

  // Road i occupies lamp_q[3i+2:3i] as {red, yellow, green}.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lamp_q <= ALL_RED;
    end else begin
      lamp_q <= {red4, yellow4, green4, red3, yellow3, green3,
                 red2, yellow2, green2, red1, yellow1, green1};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_road
      logic [2:0] ryg;
      assign ryg              = lamp_q[3*gi +: 3];
      assign road_active[gi]  = (ryg == 3'b001) || (ryg == 3'b010);
      assign road_yellow[gi]  = (ryg == 3'b010);
      assign road_illegal[gi] = !road_active[gi] && (ryg != 3'b100);
    end
  endgenerate

  always_comb begin
    active_cnt = 3'd0;
    active_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      active_cnt = active_cnt + {2'b00, road_active[i]};
      if (road_active[i]) active_idx = 2'(i);
    end
  end

  assign lamp_phase  = {active_idx, road_yellow[active_idx]};
  assign is_conflict = (active_cnt >= 3'd2);
  assign is_illegal  = |road_illegal;
  assign is_all_red  = (active_cnt == 3'd0);
  assign phase_inc   = phase_reg + 3'd1;

  // Violation priority while tracking; the first phase after SYNC may be short.
  always_comb begin
    viol_code = C_NONE;
    if (is_conflict) begin
      viol_code = C_CONFLICT;
    end else if (is_illegal) begin
      viol_code = C_ILLEGAL;
    end else if (is_all_red) begin
      viol_code = C_ALL_RED;
    end else if ((lamp_phase != phase_reg) && (lamp_phase != phase_inc)) begin
      viol_code = C_SKIP;
    end else if ((lamp_phase == phase_inc) && !first_reg && (dwell_reg < MIN_D)) begin
      viol_code = C_SHORT;
    end else if ((lamp_phase == phase_reg) && (dwell_reg >= MAX_D)) begin
      viol_code = C_STUCK;
    end
  end

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    dwell_next = dwell_reg;
    rot_next   = rot_reg;
    code_next  = code_reg;
    first_next = first_reg;
    case (state_reg)
      SYNC: begin
        if (is_conflict) begin
          state_next = FAULT;
          code_next  = C_CONFLICT;
        end else if (is_illegal) begin
          state_next = FAULT;
          code_next  = C_ILLEGAL;
        end else if (!is_all_red) begin
          state_next = TRACK;
          phase_next = lamp_phase;
          dwell_next = 8'd1;
          first_next = 1'b1;
        end
      end
      TRACK: begin
        if (viol_code != C_NONE) begin
          state_next = FAULT;
          code_next  = viol_code;
        end else if (lamp_phase == phase_inc) begin
          phase_next = lamp_phase;
          dwell_next = 8'd1;
          first_next = 1'b0;
          if (phase_reg == 3'd7) rot_next = rot_reg + ROT_W'(1);
        end else begin
          dwell_next = (dwell_reg == 8'hFF) ? dwell_reg : dwell_reg + 8'd1;
        end
      end
      FAULT: begin
        if (fault_clear) begin
          state_next = SYNC;
          code_next  = C_NONE;
          dwell_next = 8'd0;
        end
      end
      default: begin
        state_next = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= SYNC;
      phase_reg <= 3'd0;
      dwell_reg <= 8'd0;
      rot_reg   <= '0;
      code_reg  <= C_NONE;
      first_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      dwell_reg <= dwell_next;
      rot_reg   <= rot_next;
      code_reg  <= code_next;
      first_reg <= first_next;
    end
  end

  assign phase       = phase_reg;
  assign phase_valid = (state_reg == TRACK);
  assign dwell       = dwell_reg;
  assign rotations   = rot_reg;
  assign fault       = (state_reg == FAULT);
  assign fault_code  = code_reg;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: a default-parameter and a MIN=3/MAX=5 instance share
// the lamp stimulus; both are compared each cycle against a behavioural model.
module tb_traffic_light_monitor;

  localparam logic [11:0] ALLRED = 12'b100_100_100_100;
  localparam logic [11:0] CONF   = 12'b100_001_100_001;
  localparam logic [11:0] ILL2   = 12'b100_100_110_100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] lamps = ALLRED;
  logic        fault_clear = 1'b0;

  logic [2:0] f_phase, s_phase, f_code, s_code;
  logic       f_valid, s_valid, f_fault, s_fault;
  logic [7:0] f_dwell, s_dwell, f_rot, s_rot;

  int checks = 0;
  int errors = 0;
  int nstep  = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut_fast (
    .clk(clk), .reset(reset),
    .red1(lamps[2]), .yellow1(lamps[1]), .green1(lamps[0]),
    .red2(lamps[5]), .yellow2(lamps[4]), .green2(lamps[3]),
    .red3(lamps[8]), .yellow3(lamps[7]), .green3(lamps[6]),
    .red4(lamps[11]), .yellow4(lamps[10]), .green4(lamps[9]),
    .fault_clear(fault_clear),
    .phase(f_phase), .phase_valid(f_valid), .dwell(f_dwell),
    .rotations(f_rot), .fault(f_fault), .fault_code(f_code)
  );

  traffic_light_monitor #(.MIN_DWELL(3), .MAX_DWELL(5), .ROT_W(8)) dut_slow (
    .clk(clk), .reset(reset),
    .red1(lamps[2]), .yellow1(lamps[1]), .green1(lamps[0]),
    .red2(lamps[5]), .yellow2(lamps[4]), .green2(lamps[3]),
    .red3(lamps[8]), .yellow3(lamps[7]), .green3(lamps[6]),
    .red4(lamps[11]), .yellow4(lamps[10]), .green4(lamps[9]),
    .fault_clear(fault_clear),
    .phase(s_phase), .phase_valid(s_valid), .dwell(s_dwell),
    .rotations(s_rot), .fault(s_fault), .fault_code(s_code)
  );

  // Reference model: mode 0 waiting for a legal phase, 1 following, 2 latched fault.
  logic [11:0] m_lampq;
  int m_mode[2], m_phase[2], m_dwell[2], m_rot[2], m_code[2], m_first[2];
  int m_min[2] = '{1, 3};
  int m_max[2] = '{1, 5};

  function automatic logic [11:0] mk_phase(input int p);
    logic [11:0] l;
    l = ALLRED;
    l[3*(p/2) +: 3] = (p % 2 == 1) ? 3'b010 : 3'b001;
    return l;
  endfunction

  // kind: 0 one legal phase p, 1 conflict, 2 illegal lamp, 3 all red
  function automatic void classify(input logic [11:0] l, output int kind, output int p);
    int nonred, ill;
    logic [2:0] b;
    nonred = 0; ill = 0; p = 0;
    for (int i = 0; i < 4; i++) begin
      b = l[3*i +: 3];
      if (b == 3'b001) begin nonred++; p = 2*i; end
      else if (b == 3'b010) begin nonred++; p = 2*i + 1; end
      else if (b != 3'b100) ill = 1;
    end
    if (nonred >= 2) kind = 1;
    else if (ill != 0) kind = 2;
    else if (nonred == 0) kind = 3;
    else kind = 0;
  endfunction

  task automatic model_reset();
    m_lampq = ALLRED;
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = 0; m_phase[d] = 0; m_dwell[d] = 0;
      m_rot[d] = 0; m_code[d] = 0; m_first[d] = 0;
    end
  endtask

  task automatic model_step(input logic clr);
    int kind, p, nxt, code;
    classify(m_lampq, kind, p);
    for (int d = 0; d < 2; d++) begin
      if (m_mode[d] == 2) begin
        if (clr) begin m_mode[d] = 0; m_code[d] = 0; m_dwell[d] = 0; end
      end else if (m_mode[d] == 0) begin
        if (kind == 0) begin
          m_mode[d] = 1; m_phase[d] = p; m_dwell[d] = 1; m_first[d] = 1;
        end else if (kind != 3) begin
          m_mode[d] = 2; m_code[d] = kind;
        end
      end else begin
        nxt = (m_phase[d] + 1) % 8;
        code = 0;
        if (kind != 0) code = kind;
        else if (p != m_phase[d] && p != nxt) code = 4;
        else if (p == nxt && m_first[d] == 0 && m_dwell[d] < m_min[d]) code = 5;
        else if (p == m_phase[d] && m_dwell[d] >= m_max[d]) code = 6;
        if (code != 0) begin
          m_mode[d] = 2; m_code[d] = code;
        end else if (p == nxt) begin
          if (m_phase[d] == 7) m_rot[d] = (m_rot[d] + 1) % 256;
          m_phase[d] = p; m_dwell[d] = 1; m_first[d] = 0;
        end else begin
          m_dwell[d] = (m_dwell[d] >= 255) ? 255 : m_dwell[d] + 1;
        end
      end
    end
    m_lampq = lamps;
  endtask

  task automatic check_model();
    int aph, av, adw, art, af, ac, ev, ef;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        aph = f_phase; av = f_valid; adw = f_dwell; art = f_rot; af = f_fault; ac = f_code;
      end else begin
        aph = s_phase; av = s_valid; adw = s_dwell; art = s_rot; af = s_fault; ac = s_code;
      end
      ev = (m_mode[d] == 1) ? 1 : 0;
      ef = (m_mode[d] == 2) ? 1 : 0;
      checks++;
      if (aph != m_phase[d] || av != ev || adw != m_dwell[d] || art != m_rot[d] ||
          af != ef || ac != m_code[d]) begin
        errors++;
        $display("FAIL model dut%0d t=%0t actual/required phase=%0d/%0d valid=%0d/%0d dwell=%0d/%0d rot=%0d/%0d fault=%0d/%0d code=%0d/%0d",
                 d, $time, aph, m_phase[d], av, ev, adw, m_dwell[d], art, m_rot[d], af, ef, ac, m_code[d]);
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step(input logic [11:0] l, input logic c);
    lamps = l;
    fault_clear = c;
    @(posedge clk);
    #1;
    model_step(c);
    check_model();
    nstep++;
    $display("step %0d lamps=%03h clr=%0d | fast ph=%0d v=%0d dw=%0d rot=%0d f=%0d c=%0d | slow ph=%0d v=%0d dw=%0d rot=%0d f=%0d c=%0d",
             nstep, l, c, f_phase, f_valid, f_dwell, f_rot, f_fault, f_code,
             s_phase, s_valid, s_dwell, s_rot, s_fault, s_code);
  endtask

  task automatic do_reset();
    @(negedge clk);
    lamps = ALLRED;
    fault_clear = 1'b0;
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_fast_phase", f_phase, 0); chk("rst_fast_valid", f_valid, 0);
    chk("rst_fast_dwell", f_dwell, 0); chk("rst_fast_rot", f_rot, 0);
    chk("rst_fast_fault", f_fault, 0); chk("rst_fast_code", f_code, 0);
    chk("rst_slow_phase", s_phase, 0); chk("rst_slow_valid", s_valid, 0);
    chk("rst_slow_dwell", s_dwell, 0); chk("rst_slow_rot", s_rot, 0);
    chk("rst_slow_fault", s_fault, 0); chk("rst_slow_code", s_code, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [11:0] l;
    logic        clr;
    int ph, vld, dw, flt, code, rot;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [11:0] l, input logic clr,
                     input int ph, input int vld, input int dw,
                     input int flt, input int code, input int rot);
    vec_t v;
    v.l = l; v.clr = clr; v.ph = ph; v.vld = vld; v.dw = dw;
    v.flt = flt; v.code = code; v.rot = rot;
    tbl.push_back(v);
  endtask

  initial begin
    // Expected columns describe the default instance after the edge at which l is applied.
    add(mk_phase(0), 0, 0, 0, 0, 0, 0, 0);
    add(mk_phase(1), 0, 0, 1, 1, 0, 0, 0);
    add(mk_phase(2), 0, 1, 1, 1, 0, 0, 0);
    add(mk_phase(3), 0, 2, 1, 1, 0, 0, 0);
    add(CONF,        0, 3, 1, 1, 0, 0, 0);
    add(ALLRED,      0, 3, 0, 1, 1, 1, 0);
    add(CONF,        0, 3, 0, 1, 1, 1, 0);
    add(mk_phase(5), 1, 3, 0, 0, 0, 0, 0);
    add(mk_phase(6), 0, 5, 1, 1, 0, 0, 0);
    add(mk_phase(7), 0, 6, 1, 1, 0, 0, 0);
    add(mk_phase(0), 0, 7, 1, 1, 0, 0, 0);
    add(mk_phase(4), 0, 0, 1, 1, 0, 0, 1);
    add(mk_phase(4), 0, 0, 0, 1, 1, 4, 1);
    add(ILL2,        1, 0, 0, 0, 0, 0, 1);
    add(ALLRED,      0, 0, 0, 0, 1, 2, 1);
    add(ALLRED,      1, 0, 0, 0, 0, 0, 1);
    add(mk_phase(0), 0, 0, 0, 0, 0, 0, 1);
    add(mk_phase(1), 1, 0, 1, 1, 0, 0, 1);
    add(ALLRED,      1, 1, 1, 1, 0, 0, 1);
    add(ALLRED,      0, 1, 0, 1, 1, 3, 1);
    add(ALLRED,      1, 1, 0, 0, 0, 0, 1);
    add(mk_phase(2), 0, 1, 0, 0, 0, 0, 1);
    add(mk_phase(2), 0, 2, 1, 1, 0, 0, 1);
    add(mk_phase(2), 0, 2, 0, 1, 1, 6, 1);
    add(mk_phase(3), 0, 2, 0, 1, 1, 6, 1);
    add(mk_phase(3), 1, 2, 0, 0, 0, 0, 1);
    add(mk_phase(4), 0, 3, 1, 1, 0, 0, 1);
    add(mk_phase(5), 0, 4, 1, 1, 0, 0, 1);

    do_reset();
    foreach (tbl[k]) begin
      step(tbl[k].l, tbl[k].clr);
      chk($sformatf("tbl%0d_phase", k), f_phase, tbl[k].ph);
      chk($sformatf("tbl%0d_valid", k), f_valid, tbl[k].vld);
      chk($sformatf("tbl%0d_dwell", k), f_dwell, tbl[k].dw);
      chk($sformatf("tbl%0d_fault", k), f_fault, tbl[k].flt);
      chk($sformatf("tbl%0d_code", k), f_code, tbl[k].code);
      chk($sformatf("tbl%0d_rot", k), f_rot, tbl[k].rot);
    end

    // Controller stepping every cycle: phases 0..7 three times, then 0.
    do_reset();
    for (int j = 0; j < 26; j++) begin
      step(mk_phase(j < 25 ? j % 8 : 1), 0);
      if (j >= 1) begin
        chk("seq_phase", f_phase, (j - 1) % 8);
        chk("seq_dwell", f_dwell, 1);
        chk("seq_rot", f_rot, (j - 1) / 8);
        chk("seq_fault", f_fault, 0);
      end
    end

    // Long all-red from reset stays in SYNC, then 6 -> 7 -> 0 counts a rotation.
    do_reset();
    for (int j = 0; j < 10; j++) step(ALLRED, 0);
    chk("allred_valid", f_valid, 0);
    chk("allred_fault", f_fault, 0);
    chk("allred_slow_fault", s_fault, 0);
    step(mk_phase(6), 0);
    step(mk_phase(7), 0);
    chk("resync_phase", f_phase, 6);
    chk("resync_valid", f_valid, 1);
    step(mk_phase(0), 0);
    step(mk_phase(1), 0);
    chk("wrap_phase", f_phase, 0);
    chk("wrap_rot", f_rot, 1);
    step(ALLRED, 0);
    step(ALLRED, 0);
    chk("track_allred_code", f_code, 3);

    // MIN_DWELL=3: phase 2 held only two cycles mid-sequence.
    do_reset();
    for (int j = 0; j < 3; j++) step(mk_phase(0), 0);
    for (int j = 0; j < 3; j++) step(mk_phase(1), 0);
    for (int j = 0; j < 2; j++) step(mk_phase(2), 0);
    step(mk_phase(3), 0);
    chk("short_pre_valid", s_valid, 1);
    chk("short_pre_dwell", s_dwell, 2);
    step(mk_phase(3), 0);
    chk("short_fault", s_fault, 1);
    chk("short_code", s_code, 5);
    chk("short_phase", s_phase, 2);

    // MAX_DWELL=5: phase 3 held too long.
    do_reset();
    for (int j = 0; j < 6; j++) step(mk_phase(3), 0);
    chk("stuck_pre_dwell", s_dwell, 5);
    chk("stuck_pre_fault", s_fault, 0);
    step(mk_phase(3), 0);
    chk("stuck_code", s_code, 6);
    chk("stuck_dwell", s_dwell, 5);
    chk("stuck_phase", s_phase, 3);

    // Two full rotations on the slow instance, then reset in the middle of a phase.
    do_reset();
    for (int j = 0; j < 16; j++)
      for (int h = 0; h < 4; h++) step(mk_phase(j % 8), 0);
    for (int h = 0; h < 5; h++) step(mk_phase(0), 0);
    chk("pre_rst_rot", s_rot, 2);
    chk("pre_rst_dwell", s_dwell, 4);
    chk("pre_rst_valid", s_valid, 1);
    do_reset();
    step(mk_phase(0), 0);
    step(mk_phase(1), 0);
    chk("post_rst_valid", s_valid, 1);
    chk("post_rst_phase", s_phase, 0);
    chk("post_rst_dwell", s_dwell, 1);

    // Randomised controller with occasional glitches, clears and resets.
    do_reset();
    begin
      int cur, hold, r;
      logic [11:0] l;
      logic c;
      cur = 0;
      hold = 1;
      for (int n = 0; n < 1500; n++) begin
        r = $urandom_range(0, 99);
        if (r < 3) l = 12'($urandom);
        else if (r < 6) l = ALLRED;
        else if (r < 9) l = mk_phase($urandom_range(0, 7));
        else begin
          if (hold == 0) begin
            cur = (cur + 1) % 8;
            hold = $urandom_range(1, 6);
          end
          hold--;
          l = mk_phase(cur);
        end
        c = ($urandom_range(0, 15) == 0);
        step(l, c);
        if (n % 500 == 499) do_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
